// File: rtl/usb_tx_stream_packer.sv
// usb_tx_stream_packer: device-to-host byte buffer feeding the EP81 bulk-IN stream.
// Accepts IN_BYTES-wide beats, exposes a fill level, and presents bytes through a
// show-ahead output register fed from a registered-read RAM.
// Optional packet gating is enabled by defining USB_TX_PACKET_GATE_EN: bytes are
// then held back until a full MAXPKT burst is buffered, the idle timeout expires,
// or flush is pulsed.
module usb_tx_stream_packer #(
    parameter int unsigned IN_BYTES = 1,
    parameter int unsigned ASIZE    = 10,
    parameter int unsigned MAXPKT   = 32,
    parameter int unsigned TIMEOUT  = 60000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*IN_BYTES-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ASIZE:0]        level
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned PW    = ASIZE + 1;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] fptr;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_nxt;
    logic [PW-1:0] level_nxt;
    logic          wr_en;
    logic          consume;
    logic          move;
    logic          issue;
    logic          fetch_ok;

    assign wr_en     = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    // RAM stage hands its byte to the output register when that register is free or draining
    assign move      = rd_valid & (~out_valid | consume);
    // Fetch the next byte only when the RAM stage will have room for it
    assign issue     = fetch_ok & (fptr != wptr) & (~rd_valid | move);
    assign wptr_nxt  = wr_en   ? wptr + PW'(IN_BYTES) : wptr;
    assign rptr_nxt  = consume ? rptr + PW'(1)        : rptr;
    assign level_nxt = wptr_nxt - rptr_nxt;

    // Byte storage: multi-byte beat write and registered read (no reset on the array)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                mem[wptr[ASIZE-1:0] + ASIZE'(i)] <= in_data[8*i +: 8];
            end
        end
        if (issue) begin
            rd_data <= mem[fptr[ASIZE-1:0]];
        end
    end

    // Pointers, level, in_ready and the show-ahead output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            fptr      <= '0;
            level     <= '0;
            in_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            level     <= level_nxt;
            in_ready  <= (level_nxt <= PW'(DEPTH - IN_BYTES));
            if (issue) begin
                fptr <= fptr + PW'(1);
            end
            rd_valid  <= issue | (rd_valid & ~move);
            if (move) begin
                out_data <= rd_data;
            end
            out_valid <= move | (out_valid & ~consume);
        end
    end

`ifdef USB_TX_PACKET_GATE_EN
    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [PW-1:0] MAXPKT_W = PW'(MAXPKT);

    state_t        state;
    logic [15:0]   tcnt;
    logic [PW-1:0] burst;
    logic [PW-1:0] fetch_rem;
    logic          flush_pend;

    assign fetch_ok = (state == ST_SEND) && (fetch_rem != '0);

    // Gating FSM: decide when to release a burst and count its fetches and consumes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tcnt       <= 16'd0;
            burst      <= '0;
            fetch_rem  <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    flush_pend <= 1'b0;
                    if ((level != '0) &&
                        ((level >= MAXPKT_W) || (tcnt == TO_LAST) || flush || flush_pend)) begin
                        state     <= ST_SEND;
                        burst     <= (level >= MAXPKT_W) ? MAXPKT_W : level;
                        fetch_rem <= (level >= MAXPKT_W) ? MAXPKT_W : level;
                        tcnt      <= 16'd0;
                    end else if (wr_en || (level == '0)) begin
                        tcnt <= 16'd0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                ST_SEND: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (issue) begin
                        fetch_rem <= fetch_rem - PW'(1);
                    end
                    if (consume) begin
                        burst <= burst - PW'(1);
                        if (burst == PW'(1)) begin
                            state <= ST_IDLE;
                            tcnt  <= 16'd0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_gate;

    assign fetch_ok    = 1'b1;
    assign unused_gate = ^{flush, 16'(TIMEOUT), 16'(MAXPKT)};
`endif

endmodule

// File: tb/tb_usb_tx_stream_packer.sv
// Testbench for usb_tx_stream_packer: table-driven beat test, latency sequence,
// randomized wrap-around run against a byte-queue model, mid-burst reset, and
// gating sequences when USB_TX_PACKET_GATE_EN is defined.
module tb_usb_tx_stream_packer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  in1_data  = '0;
    logic        in1_valid = 1'b0;
    logic        in1_ready;
    logic        flush1    = 1'b0;
    logic [7:0]  out1_data;
    logic        out1_valid;
    logic        out1_ready = 1'b0;
    logic [3:0]  level1;

    logic [31:0] in4_data  = '0;
    logic        in4_valid = 1'b0;
    logic        in4_ready;
    logic        flush4    = 1'b0;
    logic [7:0]  out4_data;
    logic        out4_valid;
    logic        out4_ready = 1'b0;
    logic [3:0]  level4;

    int errors = 0;
    int checks = 0;
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    usb_tx_stream_packer #(.IN_BYTES(1), .ASIZE(3), .MAXPKT(4), .TIMEOUT(20)) u1 (
        .clk(clk), .rst(rst), .in_data(in1_data), .in_valid(in1_valid), .in_ready(in1_ready),
        .flush(flush1), .out_data(out1_data), .out_valid(out1_valid), .out_ready(out1_ready),
        .level(level1)
    );

    usb_tx_stream_packer #(.IN_BYTES(4), .ASIZE(3), .MAXPKT(8), .TIMEOUT(20)) u4 (
        .clk(clk), .rst(rst), .in_data(in4_data), .in_valid(in4_valid), .in_ready(in4_ready),
        .flush(flush4), .out_data(out4_data), .out_valid(out4_valid), .out_ready(out4_ready),
        .level(level4)
    );

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  elev;
        logic        erdy;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: inputs set at negedge are sampled at posedge, outputs read at next negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in1_valid = 1'b0; in4_valid = 1'b0; flush1 = 1'b0; flush4 = 1'b0;
        out1_ready = 1'b0; out4_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        q1.delete();
    endtask

    // One cycle on u1 checked against the byte-queue model
    task automatic cyc1(input logic v, input logic [7:0] d, input logic r);
        logic wr;
        logic rd;
        chk("q_level", 32'(level1), 32'(q1.size()));
        chk("q_in_ready", 32'(in1_ready), 32'(q1.size() < DEPTH));
        if (out1_valid) begin
            chk("q_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) chk("q_data", 32'(out1_data), 32'(q1[0]));
        end
        in1_valid = v; in1_data = d; out1_ready = r;
        wr = v & in1_ready;
        rd = out1_valid & r;
        step();
        if (wr) q1.push_back(d);
        if (rd && q1.size() != 0) void'(q1.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv[18];
        int nexp;
        int cons;
        int n;
        int run;
        int start2;
        int lat;
        int runs[$];

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready1", 32'(in1_ready), 32'd0);
        chk("rst_out_valid1", 32'(out1_valid), 32'd0);
        chk("rst_out_data1", 32'(out1_data), 32'd0);
        chk("rst_level1", 32'(level1), 32'd0);
        chk("rst_in_ready4", 32'(in4_ready), 32'd0);
        chk("rst_level4", 32'(level4), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_in_ready1", 32'(in1_ready), 32'd1);
        chk("rel_in_ready4", 32'(in4_ready), 32'd1);

`ifndef USB_TX_PACKET_GATE_EN
        // Ungated latency and ordering: 0x00..0x09 back-to-back, out_ready held high
        do_reset();
        out1_ready = 1'b1;
        nexp = 0;
        for (int c = 0; c < 30; c++) begin
            in1_valid = (c < 10);
            in1_data  = 8'(c);
            step();
            if (c < 2)  chk("lat_low", 32'(out1_valid), 32'd0);
            if (c == 2) chk("lat_first", 32'(out1_valid), 32'd1);
            if (out1_valid) begin
                chk("seq_data", 32'(out1_data), 32'(nexp));
                nexp++;
            end
        end
        in1_valid = 1'b0;
        chk("seq_count", 32'(nexp), 32'd10);
        chk("seq_level0", 32'(level1), 32'd0);

        // 4-byte beats into an 8-byte buffer: full, pending beat, one consume
        tv[0]  = '{1'b1, 32'h03020100, 1'b0, 1'b0, 8'h00, 4'd4, 1'b1};
        tv[1]  = '{1'b1, 32'h07060504, 1'b0, 1'b0, 8'h00, 4'd8, 1'b0};
        tv[2]  = '{1'b1, 32'h0B0A0908, 1'b0, 1'b1, 8'h00, 4'd8, 1'b0};
        tv[3]  = '{1'b1, 32'h0B0A0908, 1'b0, 1'b1, 8'h00, 4'd8, 1'b0};
        tv[4]  = '{1'b1, 32'h0B0A0908, 1'b1, 1'b1, 8'h01, 4'd7, 1'b0};
        tv[5]  = '{1'b1, 32'h0B0A0908, 1'b0, 1'b1, 8'h01, 4'd7, 1'b0};
        tv[6]  = '{1'b1, 32'h0B0A0908, 1'b1, 1'b1, 8'h02, 4'd6, 1'b0};
        tv[7]  = '{1'b1, 32'h0B0A0908, 1'b1, 1'b1, 8'h03, 4'd5, 1'b0};
        tv[8]  = '{1'b1, 32'h0B0A0908, 1'b1, 1'b1, 8'h04, 4'd4, 1'b1};
        tv[9]  = '{1'b1, 32'h0B0A0908, 1'b0, 1'b1, 8'h04, 4'd8, 1'b0};
        tv[10] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h05, 4'd7, 1'b0};
        tv[11] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h06, 4'd6, 1'b0};
        tv[12] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h07, 4'd5, 1'b0};
        tv[13] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h08, 4'd4, 1'b1};
        tv[14] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h09, 4'd3, 1'b1};
        tv[15] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0A, 4'd2, 1'b1};
        tv[16] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0B, 4'd1, 1'b1};
        tv[17] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1};
        do_reset();
        for (int i = 0; i < 18; i++) begin
            in4_valid  = tv[i].iv;
            in4_data   = tv[i].id;
            out4_ready = tv[i].ordy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(out4_valid), 32'(tv[i].ev));
            if (tv[i].ev) chk($sformatf("v%0d_data", i), 32'(out4_data), 32'(tv[i].ed));
            chk($sformatf("v%0d_level", i), 32'(level4), 32'(tv[i].elev));
            chk($sformatf("v%0d_in_ready", i), 32'(in4_ready), 32'(tv[i].erdy));
        end
        in4_valid = 1'b0; out4_ready = 1'b0;
`endif

        // Randomized wrap-around run against the byte-queue model, then drain
        do_reset();
        for (int c = 0; c < 200; c++) begin
            cyc1(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        n = 0;
        while (q1.size() != 0 && n < 400) begin
            cyc1(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("rnd_drained", 32'(q1.size()), 32'd0);
        chk("rnd_level0", 32'(level1), 32'd0);

        // Reset in the middle of a burst, then a fresh byte comes out first
        do_reset();
        for (int c = 0; c < 8; c++) begin
            in1_valid = 1'b1; in1_data = 8'(8'h10 + c);
            step();
        end
        in1_valid = 1'b0;
        cons = 0; n = 0;
        out1_ready = 1'b1;
        while (cons < 3 && n < 60) begin
            if (out1_valid) cons++;
            out1_ready = (cons < 3) || !out1_valid;
            if (cons == 3) out1_ready = 1'b0;
            step();
            n++;
        end
        out1_ready = 1'b0;
        chk("mid_consumed", 32'(cons), 32'd3);
        chk("mid_valid_before", 32'(out1_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out1_valid), 32'd0);
        chk("mid_rst_level", 32'(level1), 32'd0);
        chk("mid_rst_data", 32'(out1_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        in1_valid = 1'b1; in1_data = 8'hA5;
        step();
        in1_valid = 1'b0;
        out1_ready = 1'b1;
        n = 0;
        while (!out1_valid && n < 60) begin
            step();
            n++;
        end
        chk("post_rst_seen", 32'(out1_valid), 32'd1);
        chk("post_rst_data", 32'(out1_data), 32'hA5);
        step();
        out1_ready = 1'b0;

`ifdef USB_TX_PACKET_GATE_EN
        // Gated: 6 bytes -> burst of MAXPKT=4, gap, remaining 2 after the idle timeout
        do_reset();
        out1_ready = 1'b1;
        run = 0; start2 = -1;
        runs.delete();
        for (int c = 0; c < 100; c++) begin
            in1_valid = (c < 6);
            in1_data  = 8'(8'h40 + c);
            step();
            if (out1_valid) begin
                run++;
                if (runs.size() == 1 && run == 1) start2 = c;
            end else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
        in1_valid = 1'b0;
        chk("g_nbursts", 32'(runs.size()), 32'd2);
        if (runs.size() == 2) begin
            chk("g_burst1", 32'(runs[0]), 32'd4);
            chk("g_burst2", 32'(runs[1]), 32'd2);
        end
        chk("g_timeout_wait", 32'(start2 >= 25), 32'd1);

        // Gated: 2 bytes held until flush, burst starts within two edges of the flush edge
        do_reset();
        out1_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in1_valid = (c < 2);
            in1_data  = 8'(8'h60 + c);
            step();
            chk("f_held", 32'(out1_valid), 32'd0);
        end
        in1_valid = 1'b0;
        flush1 = 1'b1;
        step();
        flush1 = 1'b0;
        lat = 0;
        while (!out1_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("f_latency", 32'(out1_valid && lat <= 2), 32'd1);
        run = 0;
        while (out1_valid && run < 10) begin
            step();
            run++;
        end
        chk("f_burst_len", 32'(run), 32'd2);
        out1_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
